// File: rtl/id_stage.sv
// Instruction-decode stage of a 5-stage MIPS-subset pipeline: IF/ID register, register file,
// decode, load-use/branch hazard detection and early branch/jump resolution with MEM forwarding.
module id_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instruction_if,
  input  logic [31:0] NextPC_if,
  input  logic        RegWrite_wb,
  input  logic [4:0]  WriteReg_wb,
  input  logic [31:0] WriteData_wb,
  input  logic        MemRead_ex,
  input  logic        RegWrite_ex,
  input  logic [4:0]  WriteReg_ex,
  input  logic        RegWrite_mem,
  input  logic        MemtoReg_mem,
  input  logic [4:0]  WriteReg_mem,
  input  logic [31:0] ALUResult_mem,
  output logic        PC_IFWrite,
  output logic        Z,
  output logic        J,
  output logic        JR,
  output logic [31:0] BranchAddr,
  output logic [31:0] JumpAddr,
  output logic [31:0] JrAddr,
  output logic [31:0] RsData_id,
  output logic [31:0] RtData_id,
  output logic [31:0] Imm_id,
  output logic [4:0]  Rs_id,
  output logic [4:0]  Rt_id,
  output logic [4:0]  Rd_id,
  output logic        RegWrite_id,
  output logic        MemRead_id,
  output logic        MemWrite_id,
  output logic        MemtoReg_id,
  output logic        ALUSrc_id,
  output logic        RegDst_id,
  output logic [2:0]  ALUCode_id
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  function automatic logic signed [31:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  logic [31:0] Instruction_id, NextPC_id;
  logic [31:0] rf [32];
  logic [5:0]  opcode, funct;
  logic [31:0] rs_val, rt_val, rs_fwd, rt_fwd;
  logic        wb_en, flush, stall, load_use, branch_stall;
  logic        is_beq, is_bne, is_jr, is_j;
  logic        reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst;
  logic [2:0]  alu_code;
  logic        ex_hit_rs, ex_hit_rt, mem_ld_hit_rs, mem_ld_hit_rt, mem_alu_hit_rs, mem_alu_hit_rt;

  // IF/ID boundary: hold on stall, squash on redirect
  always_ff @(posedge clk) begin
    if (!reset) begin
      Instruction_id <= '0;
      NextPC_id      <= '0;
    end else if (PC_IFWrite) begin
      Instruction_id <= flush ? '0 : Instruction_if;
      NextPC_id      <= flush ? '0 : NextPC_if;
    end
  end

  assign wb_en = RegWrite_wb && (WriteReg_wb != 5'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_en) begin
      rf[WriteReg_wb] <= WriteData_wb;
    end
  end

  assign opcode = Instruction_id[31:26];
  assign funct  = Instruction_id[5:0];
  assign Rs_id  = Instruction_id[25:21];
  assign Rt_id  = Instruction_id[20:16];
  assign Rd_id  = Instruction_id[15:11];
  assign Imm_id = sign_ext16(Instruction_id[15:0]);

  always_comb begin
    rs_val = (Rs_id == 5'd0) ? '0 : rf[Rs_id];
    rt_val = (Rt_id == 5'd0) ? '0 : rf[Rt_id];
    if (wb_en && (WriteReg_wb == Rs_id)) rs_val = WriteData_wb;
    if (wb_en && (WriteReg_wb == Rt_id)) rt_val = WriteData_wb;
  end

  assign RsData_id = rs_val;
  assign RtData_id = rt_val;

  always_comb begin
    is_beq = 1'b0; is_bne = 1'b0; is_jr = 1'b0; is_j = 1'b0;
    reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    mem_to_reg = 1'b0; alu_src = 1'b0; reg_dst = 1'b0;
    alu_code = ALU_ADD;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20: begin reg_write = 1'b1; reg_dst = 1'b1; alu_code = ALU_ADD; end
          6'h22: begin reg_write = 1'b1; reg_dst = 1'b1; alu_code = ALU_SUB; end
          6'h24: begin reg_write = 1'b1; reg_dst = 1'b1; alu_code = ALU_AND; end
          6'h25: begin reg_write = 1'b1; reg_dst = 1'b1; alu_code = ALU_OR;  end
          6'h2A: begin reg_write = 1'b1; reg_dst = 1'b1; alu_code = ALU_SLT; end
          6'h08: is_jr = 1'b1;
          default: ;
        endcase
      end
      6'h23: begin reg_write = 1'b1; mem_read = 1'b1; mem_to_reg = 1'b1; alu_src = 1'b1; end
      6'h2B: begin mem_write = 1'b1; alu_src = 1'b1; end
      6'h04: is_beq = 1'b1;
      6'h05: is_bne = 1'b1;
      6'h08: begin reg_write = 1'b1; alu_src = 1'b1; end
      6'h02: is_j = 1'b1;
      default: ;
    endcase
  end

  // Hazard detection: loads in EX stall any reader; branches also wait on EX results and MEM loads
  assign load_use = MemRead_ex && (WriteReg_ex != 5'd0) &&
                    ((WriteReg_ex == Rs_id) || (WriteReg_ex == Rt_id));
  assign ex_hit_rs      = RegWrite_ex && (WriteReg_ex != 5'd0) && (WriteReg_ex == Rs_id);
  assign ex_hit_rt      = RegWrite_ex && (WriteReg_ex != 5'd0) && (WriteReg_ex == Rt_id);
  assign mem_ld_hit_rs  = RegWrite_mem && MemtoReg_mem && (WriteReg_mem != 5'd0) && (WriteReg_mem == Rs_id);
  assign mem_ld_hit_rt  = RegWrite_mem && MemtoReg_mem && (WriteReg_mem != 5'd0) && (WriteReg_mem == Rt_id);
  assign mem_alu_hit_rs = RegWrite_mem && !MemtoReg_mem && (WriteReg_mem != 5'd0) && (WriteReg_mem == Rs_id);
  assign mem_alu_hit_rt = RegWrite_mem && !MemtoReg_mem && (WriteReg_mem != 5'd0) && (WriteReg_mem == Rt_id);

  assign branch_stall = ((is_beq || is_bne || is_jr) && (ex_hit_rs || mem_ld_hit_rs)) ||
                        ((is_beq || is_bne) && (ex_hit_rt || mem_ld_hit_rt));
  assign stall      = load_use || branch_stall;
  assign PC_IFWrite = !stall;

  assign rs_fwd = mem_alu_hit_rs ? ALUResult_mem : rs_val;
  assign rt_fwd = mem_alu_hit_rt ? ALUResult_mem : rt_val;

  // Redirects resolve here, combinationally from the IF/ID contents
  assign Z  = !stall && ((is_beq && (rs_fwd == rt_fwd)) || (is_bne && (rs_fwd != rt_fwd)));
  assign J  = !stall && is_j;
  assign JR = !stall && is_jr;
  assign flush = Z || J || JR;

  assign BranchAddr = NextPC_id + {Imm_id[29:0], 2'b00};
  assign JumpAddr   = {NextPC_id[31:28], Instruction_id[25:0], 2'b00};
  assign JrAddr     = rs_fwd;

  assign RegWrite_id = reg_write  && !stall;
  assign MemRead_id  = mem_read   && !stall;
  assign MemWrite_id = mem_write  && !stall;
  assign MemtoReg_id = mem_to_reg && !stall;
  assign ALUSrc_id   = alu_src    && !stall;
  assign RegDst_id   = reg_dst    && !stall;
  assign ALUCode_id  = stall ? ALU_ADD : alu_code;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios followed by randomized traffic, all
// compared against a behavioural model of the decode stage kept in this file.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instruction_if, NextPC_if;
  logic        RegWrite_wb;
  logic [4:0]  WriteReg_wb;
  logic [31:0] WriteData_wb;
  logic        MemRead_ex, RegWrite_ex;
  logic [4:0]  WriteReg_ex;
  logic        RegWrite_mem, MemtoReg_mem;
  logic [4:0]  WriteReg_mem;
  logic [31:0] ALUResult_mem;
  logic        PC_IFWrite, Z, J, JR;
  logic [31:0] BranchAddr, JumpAddr, JrAddr, RsData_id, RtData_id, Imm_id;
  logic [4:0]  Rs_id, Rt_id, Rd_id;
  logic        RegWrite_id, MemRead_id, MemWrite_id, MemtoReg_id, ALUSrc_id, RegDst_id;
  logic [2:0]  ALUCode_id;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_instr, m_npc;
  logic [31:0] m_regs [32];
  logic        e_pcw, e_z, e_j, e_jr;
  logic [8:0]  e_ctrl;
  logic [31:0] e_rsd, e_rtd, e_imm, e_baddr, e_jaddr, e_jraddr;
  logic [14:0] e_fields;

  id_stage dut (
    .clk(clk), .reset(reset),
    .Instruction_if(Instruction_if), .NextPC_if(NextPC_if),
    .RegWrite_wb(RegWrite_wb), .WriteReg_wb(WriteReg_wb), .WriteData_wb(WriteData_wb),
    .MemRead_ex(MemRead_ex), .RegWrite_ex(RegWrite_ex), .WriteReg_ex(WriteReg_ex),
    .RegWrite_mem(RegWrite_mem), .MemtoReg_mem(MemtoReg_mem),
    .WriteReg_mem(WriteReg_mem), .ALUResult_mem(ALUResult_mem),
    .PC_IFWrite(PC_IFWrite), .Z(Z), .J(J), .JR(JR),
    .BranchAddr(BranchAddr), .JumpAddr(JumpAddr), .JrAddr(JrAddr),
    .RsData_id(RsData_id), .RtData_id(RtData_id), .Imm_id(Imm_id),
    .Rs_id(Rs_id), .Rt_id(Rt_id), .Rd_id(Rd_id),
    .RegWrite_id(RegWrite_id), .MemRead_id(MemRead_id), .MemWrite_id(MemWrite_id),
    .MemtoReg_id(MemtoReg_id), .ALUSrc_id(ALUSrc_id), .RegDst_id(RegDst_id),
    .ALUCode_id(ALUCode_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (RegWrite_wb && WriteReg_wb == idx) return WriteData_wb;
    return m_regs[idx];
  endfunction

  function automatic logic [31:0] m_fwd(input logic [4:0] idx);
    if (RegWrite_mem && !MemtoReg_mem && WriteReg_mem != 5'd0 && WriteReg_mem == idx)
      return ALUResult_mem;
    return m_read(idx);
  endfunction

  function automatic logic m_hazard(input logic [4:0] idx);
    return (RegWrite_ex && WriteReg_ex != 5'd0 && WriteReg_ex == idx) ||
           (RegWrite_mem && MemtoReg_mem && WriteReg_mem != 5'd0 && WriteReg_mem == idx);
  endfunction

  // Expected outputs for the instruction the model holds in ID, given current inputs
  task automatic compute_expected();
    logic [5:0] op, fn;
    logic [4:0] rs, rt;
    logic beq, bne, jr, jj, lu, bs, stall;
    op = m_instr[31:26]; fn = m_instr[5:0];
    rs = m_instr[25:21]; rt = m_instr[20:16];
    beq = 1'b0; bne = 1'b0; jr = 1'b0; jj = 1'b0;
    e_ctrl = 9'd0;
    case (op)
      6'h00: case (fn)
        6'h20: e_ctrl = 9'b100001_000;
        6'h22: e_ctrl = 9'b100001_001;
        6'h24: e_ctrl = 9'b100001_010;
        6'h25: e_ctrl = 9'b100001_011;
        6'h2A: e_ctrl = 9'b100001_100;
        6'h08: jr = 1'b1;
        default: ;
      endcase
      6'h23: e_ctrl = 9'b110110_000;
      6'h2B: e_ctrl = 9'b001010_000;
      6'h04: beq = 1'b1;
      6'h05: bne = 1'b1;
      6'h08: e_ctrl = 9'b100010_000;
      6'h02: jj = 1'b1;
      default: ;
    endcase
    lu = MemRead_ex && WriteReg_ex != 5'd0 && (WriteReg_ex == rs || WriteReg_ex == rt);
    bs = 1'b0;
    if (beq || bne || jr) bs = m_hazard(rs);
    if (beq || bne) bs = bs || m_hazard(rt);
    stall = lu || bs;
    e_pcw = !stall;
    if (stall) e_ctrl = 9'd0;
    e_z  = !stall && ((beq && m_fwd(rs) == m_fwd(rt)) || (bne && m_fwd(rs) != m_fwd(rt)));
    e_j  = !stall && jj;
    e_jr = !stall && jr;
    e_rsd = m_read(rs);
    e_rtd = m_read(rt);
    e_imm = 32'($signed(m_instr[15:0]));
    e_baddr  = m_npc + e_imm * 32'd4;
    e_jaddr  = (m_npc & 32'hF000_0000) | (32'(m_instr[25:0]) << 2);
    e_jraddr = m_fwd(rs);
    e_fields = {rs, rt, m_instr[15:11]};
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_pcw"},    32'(PC_IFWrite), 32'(e_pcw));
    chk({tag, "_redir"},  32'({Z, J, JR}), 32'({e_z, e_j, e_jr}));
    chk({tag, "_ctrl"},   32'({RegWrite_id, MemRead_id, MemWrite_id, MemtoReg_id,
                              ALUSrc_id, RegDst_id, ALUCode_id}), 32'(e_ctrl));
    chk({tag, "_rsdata"}, RsData_id, e_rsd);
    chk({tag, "_rtdata"}, RtData_id, e_rtd);
    chk({tag, "_imm"},    Imm_id, e_imm);
    chk({tag, "_fields"}, 32'({Rs_id, Rt_id, Rd_id}), 32'(e_fields));
    chk({tag, "_baddr"},  BranchAddr, e_baddr);
    chk({tag, "_jaddr"},  JumpAddr, e_jaddr);
    chk({tag, "_jraddr"}, JrAddr, e_jraddr);
  endtask

  task automatic update_model();
    if (!reset) begin
      m_instr = 32'd0;
      m_npc   = 32'd0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    end else begin
      if (RegWrite_wb && WriteReg_wb != 5'd0) m_regs[WriteReg_wb] = WriteData_wb;
      if (e_pcw) begin
        if (e_z || e_j || e_jr) begin
          m_instr = 32'd0;
          m_npc   = 32'd0;
        end else begin
          m_instr = Instruction_if;
          m_npc   = NextPC_if;
        end
      end
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    compute_expected();
  endtask

  task automatic end_cycle(input string tag);
    check_model(tag);
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic step(input string tag);
    at_neg();
    end_cycle(tag);
  endtask

  task automatic idle();
    RegWrite_wb = 1'b0; WriteReg_wb = 5'd0; WriteData_wb = 32'd0;
    MemRead_ex = 1'b0; RegWrite_ex = 1'b0; WriteReg_ex = 5'd0;
    RegWrite_mem = 1'b0; MemtoReg_mem = 1'b0; WriteReg_mem = 5'd0; ALUResult_mem = 32'd0;
  endtask

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08};
    logic [5:0] ops [5] = '{6'h23, 6'h2B, 6'h04, 6'h05, 6'h08};
    logic [4:0] rs, rt, rd;
    int k;
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    k  = int'($urandom_range(0, 12));
    if (k < 6) return r_type(rs, rt, rd, fns[k]);
    if (k < 11) return {ops[k - 6], rs, rt, 16'($urandom)};
    if (k == 11) return {6'h02, 26'($urandom)};
    return $urandom;
  endfunction

  initial begin
    // Reset: two cycles low, with a WB write that must be discarded
    reset = 1'b0;
    idle();
    Instruction_if = 32'h012A_4820; NextPC_if = 32'h0000_0040;
    RegWrite_wb = 1'b1; WriteReg_wb = 5'd5; WriteData_wb = 32'h0000_DEAD;
    @(posedge clk); #1;
    m_instr = 32'd0; m_npc = 32'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    at_neg();
    chk("rst_pcw", 32'(PC_IFWrite), 32'd1);
    chk("rst_redir", 32'({Z, J, JR}), 32'd0);
    chk("rst_instr_fields", 32'({Rs_id, Rt_id, Rd_id}), 32'd0);
    chk("rst_imm", Imm_id, 32'd0);
    chk("rst_regwrite", 32'(RegWrite_id), 32'd0);
    end_cycle("rst");
    reset = 1'b1;
    idle();
    for (int k = 1; k < 32; k++) begin
      Instruction_if = r_type(5'(k), 5'(k), 5'd0, 6'h20);
      step("rst_load");
      Instruction_if = 32'd0;
      at_neg();
      chk("rst_reg_zero", RsData_id, 32'd0);
      end_cycle("rst_read");
    end

    // Same-cycle WB bypass, and r0 stays zero
    Instruction_if = r_type(5'd8, 5'd0, 5'd9, 6'h20);
    step("byp_load");
    Instruction_if = 32'd0;
    RegWrite_wb = 1'b1; WriteReg_wb = 5'd8; WriteData_wb = 32'd5;
    at_neg();
    chk("bypass_rs", RsData_id, 32'd5);
    end_cycle("byp");
    idle();
    Instruction_if = r_type(5'd0, 5'd8, 5'd9, 6'h20);
    step("r0_load");
    Instruction_if = 32'd0;
    RegWrite_wb = 1'b1; WriteReg_wb = 5'd0; WriteData_wb = 32'd7;
    at_neg();
    chk("r0_during_write", RsData_id, 32'd0);
    chk("r8_written", RtData_id, 32'd5);
    end_cycle("r0w");
    idle();
    Instruction_if = r_type(5'd0, 5'd8, 5'd9, 6'h20);
    step("r0_reload");
    Instruction_if = 32'd0;
    at_neg();
    chk("r0_after_write", RsData_id, 32'd0);
    end_cycle("r0r");

    // Load-use stall: one bubble, IF/ID held
    Instruction_if = r_type(5'd8, 5'd10, 5'd9, 6'h20);
    step("lu_load");
    Instruction_if = r_type(5'd2, 5'd3, 5'd1, 6'h20);
    MemRead_ex = 1'b1; WriteReg_ex = 5'd8;
    at_neg();
    chk("lu_pcw", 32'(PC_IFWrite), 32'd0);
    chk("lu_regwrite", 32'(RegWrite_id), 32'd0);
    end_cycle("lu");
    idle();
    at_neg();
    chk("lu_release_pcw", 32'(PC_IFWrite), 32'd1);
    chk("lu_held_rs", 32'(Rs_id), 32'd8);
    chk("lu_release_regwrite", 32'(RegWrite_id), 32'd1);
    end_cycle("lu2");

    // beq taken, then exactly one flushed slot
    Instruction_if = 32'd0;
    RegWrite_wb = 1'b1; WriteReg_wb = 5'd1; WriteData_wb = 32'd7;
    step("w1");
    WriteReg_wb = 5'd2;
    step("w2");
    idle();
    Instruction_if = {6'h04, 5'd1, 5'd2, 16'd3}; NextPC_if = 32'd8;
    step("beq_load");
    Instruction_if = r_type(5'd2, 5'd3, 5'd1, 6'h20); NextPC_if = 32'd12;
    at_neg();
    chk("beq_z", 32'(Z), 32'd1);
    chk("beq_addr", BranchAddr, 32'd20);
    end_cycle("beq");
    at_neg();
    chk("flush_rs", 32'(Rs_id), 32'd0);
    chk("flush_imm", Imm_id, 32'd0);
    chk("flush_z", 32'(Z), 32'd0);
    end_cycle("flush");

    // j and jr
    Instruction_if = {6'h02, 26'd11}; NextPC_if = 32'd4;
    step("j_load");
    Instruction_if = 32'd0;
    at_neg();
    chk("j_flag", 32'(J), 32'd1);
    chk("j_addr", JumpAddr, 32'd44);
    end_cycle("j");
    RegWrite_wb = 1'b1; WriteReg_wb = 5'd3; WriteData_wb = 32'd52;
    Instruction_if = r_type(5'd3, 5'd0, 5'd0, 6'h08);
    step("jr_load");
    idle();
    Instruction_if = 32'd0;
    at_neg();
    chk("jr_flag", 32'(JR), 32'd1);
    chk("jr_addr", JrAddr, 32'd52);
    end_cycle("jr");

    // Branch operand from MEM: EX producer stalls, MEM ALU result forwards
    RegWrite_wb = 1'b1; WriteReg_wb = 5'd4; WriteData_wb = 32'd9;
    step("w4");
    idle();
    Instruction_if = {6'h04, 5'd4, 5'd0, 16'd0}; NextPC_if = 32'h100;
    step("bfw_load");
    Instruction_if = 32'd0;
    RegWrite_mem = 1'b1; MemtoReg_mem = 1'b0; WriteReg_mem = 5'd4; ALUResult_mem = 32'd0;
    RegWrite_ex = 1'b1; WriteReg_ex = 5'd4;
    at_neg();
    chk("bex_pcw", 32'(PC_IFWrite), 32'd0);
    chk("bex_z", 32'(Z), 32'd0);
    end_cycle("bex");
    RegWrite_ex = 1'b0; WriteReg_ex = 5'd0;
    at_neg();
    chk("bmem_z", 32'(Z), 32'd1);
    chk("bmem_pcw", 32'(PC_IFWrite), 32'd1);
    end_cycle("bmem");
    idle();

    // Reset during a stall wins, and the concurrent WB write is dropped
    Instruction_if = r_type(5'd8, 5'd10, 5'd9, 6'h20);
    step("rs_load");
    MemRead_ex = 1'b1; WriteReg_ex = 5'd8;
    RegWrite_wb = 1'b1; WriteReg_wb = 5'd8; WriteData_wb = 32'd99;
    reset = 1'b0;
    step("rst_stall");
    reset = 1'b1;
    idle();
    Instruction_if = r_type(5'd8, 5'd0, 5'd9, 6'h20);
    at_neg();
    chk("rst_stall_rs", 32'(Rs_id), 32'd0);
    chk("rst_stall_pcw", 32'(PC_IFWrite), 32'd1);
    end_cycle("rst_stall2");
    Instruction_if = 32'd0;
    at_neg();
    chk("rst_wb_dropped", RsData_id, 32'd0);
    end_cycle("rst_wb");

    // Reset during a redirect
    Instruction_if = {6'h02, 26'd5}; NextPC_if = 32'd16;
    step("rj_load");
    reset = 1'b0;
    step("rst_flush");
    reset = 1'b1;
    at_neg();
    chk("rst_flush_j", 32'(J), 32'd0);
    end_cycle("rst_flush2");

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      reset          = ($urandom_range(0, 39) != 0);
      Instruction_if = rand_instr();
      NextPC_if      = $urandom & 32'hFFFF_FFFC;
      RegWrite_wb    = 1'($urandom_range(0, 1));
      WriteReg_wb    = 5'($urandom_range(0, 7));
      WriteData_wb   = $urandom_range(0, 3);
      MemRead_ex     = ($urandom_range(0, 3) == 0);
      RegWrite_ex    = ($urandom_range(0, 3) == 0);
      WriteReg_ex    = 5'($urandom_range(0, 7));
      RegWrite_mem   = 1'($urandom_range(0, 1));
      MemtoReg_mem   = ($urandom_range(0, 3) == 0);
      WriteReg_mem   = 5'($urandom_range(0, 7));
      ALUResult_mem  = $urandom_range(0, 3);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
